// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 16 x WORD_LENGTH register bank with two combinational read ports,
// one negedge write port and a per-register pending-write scoreboard for RAW hazard detection.
// Optional build macro: REG_FILE_BYPASS_EN (forward writeback data to reads, mask the last hazard).
module reg_file_scoreboard #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned PEND_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en1,
  input  logic [3:0]             rd_addr1,
  output logic [WORD_LENGTH-1:0] rd_data1,
  input  logic                   rd_en2,
  input  logic [3:0]             rd_addr2,
  output logic [WORD_LENGTH-1:0] rd_data2,
  input  logic                   issue_en,
  input  logic [3:0]             issue_dest,
  input  logic                   wb_en,
  input  logic [3:0]             wb_addr,
  input  logic [WORD_LENGTH-1:0] wb_data,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic                   sb_err
);

  localparam logic [PEND_W-1:0] CntMax = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CntOne = PEND_W'(1);

  logic [WORD_LENGTH-1:0] regs_q [16];
  logic [PEND_W-1:0]      cnt_q  [16];
  logic [PEND_W-1:0]      cnt_d  [16];
  logic                   sb_err_q, sb_err_d;
  logic [15:0]            inc_vec, dec_vec;

  // One-hot per-register issue/writeback strobes.
  assign inc_vec = {15'b0, issue_en} << issue_dest;
  assign dec_vec = {15'b0, wb_en} << wb_addr;

  // Register bank: written mid-cycle so same-cycle reads see the new value in the second half.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Scoreboard next state: saturate on over/underflow and raise the sticky error instead.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CntMax) sb_err_d = 1'b1;
        else                    cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

`ifdef REG_FILE_BYPASS_EN
  logic fwd1, fwd2;

  assign fwd1     = wb_en && (wb_addr == rd_addr1);
  assign fwd2     = wb_en && (wb_addr == rd_addr2);
  assign rd_data1 = fwd1 ? wb_data : regs_q[rd_addr1];
  assign rd_data2 = fwd2 ? wb_data : regs_q[rd_addr2];
  // The last outstanding write is being forwarded, so it no longer blocks the reader.
  assign hazard1  = rd_en1 && (cnt_q[rd_addr1] != '0) && !(fwd1 && (cnt_q[rd_addr1] == CntOne));
  assign hazard2  = rd_en2 && (cnt_q[rd_addr2] != '0) && !(fwd2 && (cnt_q[rd_addr2] == CntOne));
`else
  assign rd_data1 = regs_q[rd_addr1];
  assign rd_data2 = regs_q[rd_addr2];
  assign hazard1  = rd_en1 && (cnt_q[rd_addr1] != '0);
  assign hazard2  = rd_en2 && (cnt_q[rd_addr2] != '0);
`endif

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: expectations are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled. Honours REG_FILE_BYPASS_EN.
module tb_reg_file_scoreboard;

`ifdef REG_FILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en1, rd_en2, issue_en, wb_en;
  logic [3:0]  rd_addr1, rd_addr2, issue_dest, wb_addr;
  logic [31:0] wb_data, rd_data1, rd_data2;
  logic        hazard1, hazard2, sb_err;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard #(.WORD_LENGTH(32), .PEND_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en1     (rd_en1),
    .rd_addr1   (rd_addr1),
    .rd_data1   (rd_data1),
    .rd_en2     (rd_en2),
    .rd_addr2   (rd_addr2),
    .rd_data2   (rd_data2),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .sb_err     (sb_err)
  );

  task automatic push(input string n, input logic [31:0] v);
    exp_t t;
    t.name = n;
    t.val  = v;
    exp_q.push_back(t);
  endtask

  task automatic idle();
    rd_en1 = 0; rd_addr1 = 0; rd_en2 = 0; rd_addr2 = 0;
    issue_en = 0; issue_dest = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  // Inputs for a cycle are driven just after its opening posedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rd_en1 = 1; rd_addr1 = 3;
    #1;
    push("por_rd", 32'h0); push("por_hz", 32'h0); push("por_err", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
    // Build cnt[3]=2 and R3=DEADBEEF, then reset mid-cycle.
    next_cycle(); issue_en = 1; issue_dest = 3;
    next_cycle();
    next_cycle(); wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
    mid_cycle();
    push("pre_rst_rd", 32'hDEADBEEF); push("pre_rst_hz", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    rst = 1;
    #1;
    push("rst_rd", 32'h0); push("rst_hz", 32'h0); push("rst_err", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
    idle();
    #1 rst = 0;
  endtask

  task automatic test_write_read();
    exp_t e;
    next_cycle(); idle(); issue_en = 1; issue_dest = 5; rd_en1 = 1; rd_addr1 = 5; rd_addr2 = 6;
    next_cycle(); issue_en = 0; wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
    #1;
    push("wr_early", Bypass ? 32'h12345678 : 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    mid_cycle();
    push("wr_rd1", 32'h12345678); push("wr_rd2_other", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data2 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data2, e.val); end
    next_cycle(); wb_en = 0;
    #1;
    push("wr_err", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
  endtask

  task automatic test_raw_hazard();
    exp_t e;
    next_cycle(); idle(); issue_en = 1; issue_dest = 7; rd_en1 = 1; rd_addr1 = 7;
    #1;
    push("raw_c0", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); issue_en = 0;
    #1;
    push("raw_c1", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); rd_en1 = 0;
    #1;
    push("raw_rd_dis", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    rd_en1 = 1;
    #1;
    push("raw_c2", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); wb_en = 1; wb_addr = 7; wb_data = 32'h77;
    #1;
    push("raw_c3_wb", Bypass ? 32'h0 : 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); wb_en = 0;
    #1;
    push("raw_c4", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
  endtask

  task automatic test_multi_inflight();
    exp_t e;
    next_cycle(); idle(); issue_en = 1; issue_dest = 2; rd_en1 = 1; rd_addr1 = 2;
    next_cycle();
    next_cycle(); issue_en = 0; wb_en = 1; wb_addr = 2; wb_data = 32'h1;
    next_cycle(); wb_en = 0;
    #1;
    push("mul_cnt1", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); issue_en = 1; issue_dest = 2; wb_en = 1; wb_addr = 2; wb_data = 32'h2;
    next_cycle(); issue_en = 0; wb_en = 0;
    #1;
    push("mul_same_cyc", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); wb_en = 1; wb_addr = 2; wb_data = 32'h3;
    next_cycle(); wb_en = 0;
    #1;
    push("mul_cnt0", 32'h0); push("mul_err", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
  endtask

  task automatic test_underflow();
    exp_t e;
    next_cycle(); idle(); issue_en = 1; issue_dest = 4; wb_en = 1; wb_addr = 4;
    wb_data = 32'hCAFEF00D; rd_en1 = 1; rd_addr1 = 4;
    mid_cycle();
    push("uf_simul_rd", 32'hCAFEF00D);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    next_cycle(); issue_en = 0; wb_en = 0;
    #1;
    push("uf_simul_err", 32'h0); push("uf_simul_hz", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    next_cycle(); wb_en = 1; wb_addr = 4; wb_data = 32'hA5A5A5A5;
    next_cycle(); wb_en = 0;
    #1;
    push("uf_rd", 32'hA5A5A5A5); push("uf_hz", 32'h0); push("uf_err", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_data1 !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, rd_data1, e.val); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
    // Clear the sticky error so the overflow scenario starts clean.
    idle();
    rst = 1;
    #1 rst = 0;
    #1;
    push("uf_err_cleared", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
  endtask

  task automatic test_overflow();
    exp_t e;
    next_cycle(); idle(); issue_en = 1; issue_dest = 9; rd_en1 = 1; rd_addr1 = 9;
    rd_en2 = 1; rd_addr2 = 10;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    push("ov_err_at3", 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
    next_cycle(); issue_en = 0;
    #1;
    push("ov_err_at4", 32'h1); push("ov_hz", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    // Drain two writes (one alongside an unrelated issue to R10): saturated count 3 leaves 1.
    next_cycle(); wb_en = 1; wb_addr = 9; wb_data = 32'h9;
    next_cycle(); issue_en = 1; issue_dest = 10;
    next_cycle(); issue_en = 0; wb_en = 0;
    #1;
    push("ov_hz_cnt1", 32'h1); push("ov_hz2_r10", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (hazard2 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard2, e.val[0]); end
    next_cycle(); wb_en = 1; wb_addr = 9;
    next_cycle(); wb_en = 0;
    #1;
    push("ov_hz_cnt0", 32'h0); push("ov_err_sticky", 32'h1);
    e = exp_q.pop_front(); n_cmp++;
    if (hazard1 !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, hazard1, e.val[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (sb_err !== e.val[0]) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, sb_err, e.val[0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_raw_hazard();
    test_multi_inflight();
    test_underflow();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- 16 x WORD_LENGTH register bank for the ARM core.
- Two asynchronous read ports serve the decode stage; one write port takes writeback.
- Write-data is captured on negedge clk, so a same-cycle read returns the new value in the second half-cycle.
- A per-register pending-write scoreboard, updated on posedge clk, flags read-after-write hazards to the hazard unit.

Parameters:
- WORD_LENGTH, 32, data width of each register and data port.
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- rd_en1  input  1  read port 1 source is used by the instruction in decode.
- rd_addr1  input  4  read port 1 register index.
- rd_data1  output  WORD_LENGTH  read port 1 data.
- rd_en2  input  1  read port 2 source is used.
- rd_addr2  input  4  read port 2 register index.
- rd_data2  output  WORD_LENGTH  read port 2 data.
- issue_en  input  1  instruction leaving decode will write issue_dest.
- issue_dest  input  4  destination register of the issuing instruction.
- wb_en  input  1  writeback valid this cycle.
- wb_addr  input  4  writeback register index.
- wb_data  input  WORD_LENGTH  writeback data.
- hazard1  output  1  port 1 source has an outstanding write.
- hazard2  output  1  port 2 source has an outstanding write.
- sb_err  output  1  sticky scoreboard over/underflow error.

Behaviour:
- Reset (async, any time, including mid-operation): all 16 registers = 0; all pending counters = 0; sb_err = 0. In-flight issue/wb state is discarded.
- Register write: on negedge clk, if wb_en, then reg[wb_addr] <= wb_data. No other register changes.
- Reads: combinational; rd_dataN = reg[rd_addrN]. There is no zero register; all 16 indices are writable.
- Scoreboard: on posedge clk, for each index r:
  - inc = issue_en && issue_dest==r
  - dec = wb_en && wb_addr==r
  - inc && !dec: cnt[r]+1. If cnt[r] is already 2^PEND_W-1, it holds and sb_err <= 1.
  - dec && !inc: cnt[r]-1. If cnt[r] is already 0, it holds at 0 and sb_err <= 1.
  - inc && dec (same r, same cycle): cnt[r] unchanged. No error, including when cnt=0.
  - Neither: unchanged.
- sb_err is sticky and clears only on rst.
- Hazard: hazardN = rd_enN && (cnt[rd_addrN] != 0). Combinational from current counters; no registered latency. With rd_enN=0, hazardN=0 regardless of counters.
- Issue and wb to different registers in the same cycle are independent.
- wb_en is held for a full clock cycle. The negedge data write and the posedge counter decrement belong to the same cycle.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - rd_dataN = wb_data whenever wb_en && wb_addr==rd_addrN, for the whole cycle. Otherwise rd_dataN = reg[rd_addrN].
  - hazardN is suppressed when cnt[rd_addrN]==1 && wb_en && wb_addr==rd_addrN, because the value is already forwarded.
- Undefined:
  - No bypass mux; reads see the new value only after the negedge write.
  - hazardN stays asserted until the posedge that decrements the counter to 0.
- Register/counter update timing is identical in both builds.

Test Plan:
- Reset check: assert rst mid-cycle after writing R3=0xDEADBEEF with cnt[3]=2 -> rd_data for R3 reads 0, hazard=0 with rd_en1=1, sb_err=0, all immediately, without a clock edge.
- Write/read: wb_en=1, wb_addr=5, wb_data=0x12345678 for one cycle -> rd_data1 (rd_addr1=5) = 0x12345678 after the negedge. Bypass build: the same value is valid from the start of the cycle.
- RAW hazard: issue_dest=7 at cycle 0 -> hazard1=1 (rd_en1=1, rd_addr1=7) from cycle 1. wb R7 at cycle 3 -> hazard1=0 after posedge 4. Bypass build: hazard1=0 during cycle 3. rd_en1=0 -> hazard1=0 throughout.
- Multiple in-flight: issue R2 twice, then wb R2 once -> cnt=1, hazard still 1. Second wb -> hazard 0. Simultaneous issue R2 + wb R2 with cnt=1 -> cnt stays 1.
- Overflow: four issues to R9 with no wb (PEND_W=2) -> cnt saturates at 3, sb_err=1 after the 4th posedge, and sb_err stays 1 through subsequent traffic.
- Underflow: wb R4 with cnt[4]=0 and no issue -> data is written, cnt stays 0, sb_err=1. Simultaneous issue R4 + wb R4 at cnt=0 -> sb_err stays 0.
